// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and limits for the clock timekeeping stages
package clock_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_HOLD,
        BTN_REPEAT
    } btn_state_t;

    typedef enum logic [1:0] {
        HR_IDLE,
        HR_PULSE,
        HR_GAP
    } hr_state_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - button edge detect with hold-to-auto-repeat step strobe
module btn_repeat
    import clock_pkg::*;
#(
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 200
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_step
);

    localparam int CW = $clog2(max_int(HOLD_MS, REPEAT_MS));
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MS - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_MS - 1);

    btn_state_t    r_state;
    btn_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_btn_prev;
    logic          w_rise;

    // A button already held when reset lifts must be released before it counts
    assign w_rise = i_btn & ~r_btn_prev;

    // State register, shared hold/repeat counter and previous button level
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= BTN_IDLE;
            r_cnt      <= '0;
            r_btn_prev <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_btn_prev <= i_btn;
        end
    end

    // Next state and step strobe; counter restarts on every state change
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_step      = 1'b0;
        case (r_state)
            BTN_IDLE: begin
                if (w_rise) begin
                    o_step      = 1'b1;
                    w_state_nxt = BTN_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            BTN_HOLD: begin
                if (!i_btn) begin
                    w_state_nxt = BTN_IDLE;
                end else if (r_cnt == HOLD_LAST) begin
                    o_step      = 1'b1;
                    w_state_nxt = BTN_REPEAT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            BTN_REPEAT: begin
                if (!i_btn) begin
                    w_state_nxt = BTN_IDLE;
                end else if (r_cnt == RPT_LAST) begin
                    o_step    = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = BTN_IDLE;
        endcase
    end

endmodule

// File: rtl/minutes.sv
// rtl/minutes.sv - ms/second/minute counting, set buttons and spaced hour pulses
module minutes
    import clock_pkg::*;
#(
    parameter int MS_PER_SEC = 1000,
    parameter int HOLD_MS    = 500,
    parameter int REPEAT_MS  = 200,
    parameter int HOUR_GAP   = 4
) (
    input  logic       clkMSec,
    input  logic       reset,
    input  logic       runClock,
    input  logic       minuteBtn,
    input  logic       hourBtn,
    output logic [5:0] second,
    output logic [5:0] minute,
    output logic       changeHour
);

    localparam int MSW = $clog2(MS_PER_SEC);
    localparam logic [MSW-1:0] MS_LAST = MSW'(MS_PER_SEC - 1);
    // Pulse cycle + gap cycles + one idle cycle add up to HOUR_GAP
    localparam int GW = (HOUR_GAP > 3) ? $clog2(HOUR_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(HOUR_GAP - 3);

    logic [MSW-1:0] r_ms;
    logic [5:0]     r_second;
    logic [5:0]     r_minute;
    logic [1:0]     r_pend;
    hr_state_t      r_hr_state;
    hr_state_t      w_hr_nxt;
    logic [GW-1:0]  r_gap_cnt;
    logic [GW-1:0]  w_gap_nxt;
    logic           w_min_step;
    logic           w_hr_step;
    logic           w_tick;
    logic           w_nat_hour;
    logic [2:0]     w_req_cnt;
    logic [2:0]     w_pend_sum;
    logic [1:0]     w_pend_nxt;

    btn_repeat #(
        .HOLD_MS  (HOLD_MS),
        .REPEAT_MS(REPEAT_MS)
    ) u_min_btn (
        .i_clk  (clkMSec),
        .i_reset(reset),
        .i_btn  (minuteBtn),
        .o_step (w_min_step)
    );

    btn_repeat #(
        .HOLD_MS  (HOLD_MS),
        .REPEAT_MS(REPEAT_MS)
    ) u_hr_btn (
        .i_clk  (clkMSec),
        .i_reset(reset),
        .i_btn  (hourBtn),
        .o_step (w_hr_step)
    );

    assign w_tick     = runClock && (r_ms == MS_LAST);
    assign w_nat_hour = w_tick && (r_second == SEC_MAX) && (r_minute == MIN_MAX);

    // Timekeeping; a 59:59 carry overrides a coincident manual minute step
    always_ff @(posedge clkMSec) begin
        if (reset) begin
            r_ms     <= '0;
            r_second <= '0;
            r_minute <= '0;
        end else if (w_nat_hour) begin
            r_ms     <= '0;
            r_second <= '0;
            r_minute <= '0;
        end else if (w_min_step) begin
            r_ms     <= '0;
            r_second <= '0;
            r_minute <= (r_minute == MIN_MAX) ? 6'd0 : r_minute + 6'd1;
        end else if (w_tick) begin
            r_ms <= '0;
            if (r_second == SEC_MAX) begin
                r_second <= '0;
                r_minute <= (r_minute == MIN_MAX) ? 6'd0 : r_minute + 6'd1;
            end else begin
                r_second <= r_second + 6'd1;
            end
        end else if (runClock) begin
            r_ms <= r_ms + MSW'(1);
        end
    end

    // Pending count: retire the pulsed request first, then add new ones, cap at 3
    assign w_req_cnt  = {2'b00, w_nat_hour} + {2'b00, w_hr_step};
    assign w_pend_sum = {1'b0, r_pend} - {2'b00, (r_hr_state == HR_PULSE)} + w_req_cnt;
    assign w_pend_nxt = (w_pend_sum > 3'd3) ? 2'd3 : w_pend_sum[1:0];

    // Hour FSM state, gap counter and pending request count
    always_ff @(posedge clkMSec) begin
        if (reset) begin
            r_hr_state <= HR_IDLE;
            r_gap_cnt  <= '0;
            r_pend     <= '0;
        end else begin
            r_hr_state <= w_hr_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_pend     <= w_pend_nxt;
        end
    end

    // Hour FSM next state; a request seen in IDLE pulses on the following cycle
    always_comb begin
        w_hr_nxt  = r_hr_state;
        w_gap_nxt = r_gap_cnt;
        case (r_hr_state)
            HR_IDLE: begin
                if ((r_pend != 2'd0) || (w_req_cnt != 3'd0)) begin
                    w_hr_nxt = HR_PULSE;
                end
            end
            HR_PULSE: begin
                w_hr_nxt  = HR_GAP;
                w_gap_nxt = '0;
            end
            HR_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_hr_nxt = HR_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + GW'(1);
                end
            end
            default: w_hr_nxt = HR_IDLE;
        endcase
    end

    assign second     = r_second;
    assign minute     = r_minute;
    assign changeHour = (r_hr_state == HR_PULSE);

endmodule
